// File: rtl/seg_disp_arbiter.sv
// Round-robin owner of the shared 8-digit seven-segment display.
// A minimum hold time stops sources from flickering in and out.
module seg_disp_arbiter #(
  parameter int NREQ        = 4,
  parameter int HOLD_CYCLES = 1000,
  parameter int IDW         = $clog2(NREQ),
  parameter int CW          = $clog2(HOLD_CYCLES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [32*NREQ-1:0]   data_flat,
  input  logic [8*NREQ-1:0]    blank_flat,
  output logic [NREQ-1:0]      grant,
  output logic [IDW-1:0]       owner_id,
  output logic                 busy,
  output logic [31:0]          disp_data,
  output logic [7:0]           disp_blank
);

  localparam int CNTW = (CW < 1) ? 1 : CW;
  localparam logic [CNTW-1:0] HOLD_LD = CNTW'(HOLD_CYCLES - 1);
  localparam logic [IDW-1:0]  LAST_RST = IDW'(NREQ - 1);

  typedef enum logic {
    IDLE,
    OWN
  } state_e;

  state_e          state_q;
  logic [IDW-1:0]  last_q;
  logic [CNTW-1:0] cnt_q;

  logic [NREQ-1:0] cand;
  logic            pick_vld;
  logic [IDW-1:0]  pick_id;
  logic            own_req;
  logic [31:0]     pick_data;
  logic [7:0]      pick_blank;
  logic [31:0]     own_data;
  logic [7:0]      own_blank;
  logic            take;
  logic            rel;
  logic            keep;

  // The current owner never competes against itself.
  always_comb begin
    cand = req;
    if (state_q == OWN) begin
      cand = req & ~grant;
    end
  end

  // Nearest set bit after last_q wins; walk backwards so it lands last.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (cand[(int'(last_q) + k) % NREQ]) begin
        pick_vld = 1'b1;
        pick_id  = IDW'((int'(last_q) + k) % NREQ);
      end
    end
  end

  always_comb begin
    own_req    = req[owner_id];
    pick_data  = data_flat[32*pick_id +: 32];
    pick_blank = blank_flat[8*pick_id +: 8];
    own_data   = data_flat[32*owner_id +: 32];
    own_blank  = blank_flat[8*owner_id +: 8];
  end

  always_comb begin
    take = 1'b0;
    rel  = 1'b0;
    keep = 1'b0;
    if (state_q == IDLE) begin
      take = pick_vld;
    end else if (!own_req) begin
      take = pick_vld;
      rel  = !pick_vld;
    end else if (cnt_q == '0 && pick_vld) begin
      take = 1'b1;
    end else begin
      keep = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant      <= '0;
      owner_id   <= '0;
      busy       <= 1'b0;
      disp_data  <= '0;
      disp_blank <= 8'hFF;
      cnt_q      <= '0;
      last_q     <= LAST_RST;
    end else begin
      unique case (1'b1)
        take: begin
          state_q    <= OWN;
          grant      <= NREQ'(1) << pick_id;
          owner_id   <= pick_id;
          busy       <= 1'b1;
          last_q     <= pick_id;
          cnt_q      <= HOLD_LD;
          disp_data  <= pick_data;
          disp_blank <= pick_blank;
        end
        rel: begin
          state_q    <= IDLE;
          grant      <= '0;
          owner_id   <= '0;
          busy       <= 1'b0;
          disp_data  <= '0;
          disp_blank <= 8'hFF;
        end
        keep: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end
          disp_data  <= own_data;
          disp_blank <= own_blank;
        end
        default: begin
          state_q <= state_q;
        end
      endcase
    end
  end

endmodule
